// File: rtl/toggle_event_arbiter.sv
// toggle_event_arbiter: latches per-requester single-cycle events and grants
// them round-robin onto one toggle-based CDC event channel, one in flight.
// Optional WAIT timeout is built when CDC_ARB_TIMEOUT_EN is defined.
module toggle_event_arbiter #(
  parameter int unsigned N              = 4,
  parameter int unsigned ID_WIDTH       = 2,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic                ack_toggle,
  output logic                req_toggle,
  output logic [ID_WIDTH-1:0] req_id,
  output logic                busy,
  output logic [N-1:0]        done,
  output logic [N-1:0]        overflow,
  output logic                spurious_ack,
  output logic                timeout
);

  // Elaboration-time parameter sanity checks
  if (N < 2 || N > 16) begin : g_bad_n
    $error("toggle_event_arbiter: N must be 2..16");
  end
  if ((1 << ID_WIDTH) < N) begin : g_bad_id_width
    $error("toggle_event_arbiter: ID_WIDTH too small for N");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("toggle_event_arbiter: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("toggle_event_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                 state;
  logic [ID_WIDTH-1:0]    rr_ptr;
  logic [N-1:0]           pending;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_q;
  logic                   ack_pulse;
  logic                   grant_valid;
  logic                   grant_fire;
  logic [ID_WIDTH-1:0]    grant_id;
  logic [N-1:0]           grant_mask;
  logic [N-1:0]           done_mask;

  // Synchronize the destination ack toggle and keep one extra flop for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= '0;
      ack_q    <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_toggle};
      ack_q    <= ack_sync[SYNC_STAGES-1];
    end
  end

  assign ack_pulse = ack_q ^ ack_sync[SYNC_STAGES-1];

  // Round-robin pick: pending requester closest to rr_ptr going upward mod N
  always_comb begin
    int unsigned rr;
    int unsigned d;
    int unsigned best_d;
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_mask  = '0;
    done_mask   = '0;
    rr          = 32'(rr_ptr);
    d           = 0;
    best_d      = N;
    for (int unsigned j = 0; j < N; j++) begin
      d = (j >= rr) ? (j - rr) : (j + N - rr);
      if (pending[j] && d < best_d) begin
        best_d      = d;
        grant_valid = 1'b1;
        grant_id    = ID_WIDTH'(j);
      end
    end
    grant_fire = (state == ST_IDLE) && grant_valid;
    for (int unsigned j = 0; j < N; j++) begin
      grant_mask[j] = grant_fire && (grant_id == ID_WIDTH'(j));
      done_mask[j]  = (req_id == ID_WIDTH'(j));
    end
  end

  // Event latches: a grant clears its bit unless a fresh event lands that same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~grant_mask) | req;
      overflow <= req & pending & ~grant_mask;
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`endif

  // Grant/ack FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      req_toggle   <= 1'b0;
      req_id       <= '0;
      busy         <= 1'b0;
      done         <= '0;
      spurious_ack <= 1'b0;
`ifdef CDC_ARB_TIMEOUT_EN
      timeout      <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      done         <= '0;
      spurious_ack <= 1'b0;
`ifdef CDC_ARB_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (ack_pulse) spurious_ack <= 1'b1;
          if (grant_valid) begin
            req_id     <= grant_id;
            req_toggle <= ~req_toggle;
            busy       <= 1'b1;
            rr_ptr     <= (grant_id == ID_WIDTH'(N - 1)) ? '0 : grant_id + ID_WIDTH'(1);
            state      <= ST_WAIT;
`ifdef CDC_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (ack_pulse) begin
            done  <= done_mask;
            busy  <= 1'b0;
            state <= ST_IDLE;
`ifdef CDC_ARB_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef CDC_ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_event_arbiter.sv
// Bench for toggle_event_arbiter: table of request rounds plus hand sequences
// for latency, overflow, spurious ack, reset mid-WAIT and (optional) timeout.
module tb_toggle_event_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned SS  = 2;
`ifdef CDC_ARB_TIMEOUT_EN
  localparam int unsigned TO  = 16;
`else
  localparam int unsigned TO  = 1024;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic           ack_toggle;
  logic           req_toggle;
  logic [IDW-1:0] req_id;
  logic           busy;
  logic [N-1:0]   done;
  logic [N-1:0]   overflow;
  logic           spurious_ack;
  logic           timeout;

  toggle_event_arbiter #(.N(N), .ID_WIDTH(IDW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .ack_toggle(ack_toggle),
    .req_toggle(req_toggle), .req_id(req_id), .busy(busy), .done(done),
    .overflow(overflow), .spurious_ack(spurious_ack), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int flips = 0;
  int done_pulses = 0;
  int spur_pulses = 0;
  int ovf1_pulses = 0;
  int last_id = 0;
  int manual_acks = 0;
  int acks_done = 0;
  bit auto_ack = 1'b0;
  logic prev_toggle = 1'b0;

  typedef struct {
    bit         do_rst;
    logic [3:0] req;
    int         n;
    logic [7:0] ids;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard grants, check done, count pulses, act as destination acker
  always @(posedge clk) begin
    int e;
    #1;
    if (rst) begin
      prev_toggle = req_toggle;
      ack_toggle  = 1'b0;
      acks_done   = manual_acks;
    end else begin
      if (req_toggle !== prev_toggle) begin
        prev_toggle = req_toggle;
        flips++;
        if (exp_q.size() == 0) begin
          check("grant_unexpected", 32'(req_id) + 32'h100, 32'(req_id));
        end else begin
          e = exp_q.pop_front();
          check("grant_id", 32'(req_id), e);
        end
        last_id = int'(req_id);
        if (auto_ack) ack_toggle = ~ack_toggle;
      end
      if (manual_acks != acks_done) begin
        acks_done  = manual_acks;
        ack_toggle = ~ack_toggle;
      end
      if (done != '0) begin
        done_pulses++;
        check("done_onehot", 32'(done), 32'(1) << last_id);
      end
      if (spurious_ack) spur_pulses++;
      if (overflow[1]) ovf1_pulses++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'(exp_q.size()), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int f0, d0, s0, o0, cnt;
    rst = 1'b1;
    req = '0;
    ack_toggle = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Test 1: reset state, single event latency, ack-to-done latency
    do_reset();
    check("rst_req_toggle", 32'(req_toggle), 0);
    check("rst_req_id", 32'(req_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_spurious", 32'(spurious_ack), 0);
    check("rst_timeout", 32'(timeout), 0);
    auto_ack = 1'b0;
    exp_q.push_back(0);
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk); #1;
    check("t1_no_flip_at_sample_edge", 32'(req_toggle), 0);
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    check("t1_toggle", 32'(req_toggle), 1);
    check("t1_req_id", 32'(req_id), 0);
    check("t1_busy", 32'(busy), 1);
    @(negedge clk);
    manual_acks++;
    @(posedge clk); #1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      cnt++;
      if (done != '0) break;
    end
    check("t1_done_latency", cnt, SS + 1);
    check("t1_done", 32'(done), 32'h1);
    check("t1_busy_after_done", 32'(busy), 0);
    @(posedge clk); #1;
    check("t1_done_one_cycle", 32'(done), 0);

    // Table-driven rounds with auto-ack
    vecs[0] = '{1'b1, 4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{1'b0, 4'b0011, 2, {2'd0, 2'd0, 2'd1, 2'd0}};
    vecs[2] = '{1'b0, 4'b1000, 1, {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[3] = '{1'b0, 4'b0101, 2, {2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[4] = '{1'b0, 4'b1010, 2, {2'd0, 2'd0, 2'd1, 2'd3}};
    vecs[5] = '{1'b1, 4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}};
    auto_ack = 1'b1;
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_rst) do_reset();
      f0 = flips;
      d0 = done_pulses;
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(int'(vecs[v].ids[2*k +: 2]));
      pulse_req(vecs[v].req);
      wait_idle($sformatf("vec%0d_stuck", v));
      check($sformatf("vec%0d_flips", v), flips - f0, vecs[v].n);
      check($sformatf("vec%0d_dones", v), done_pulses - d0, vecs[v].n);
      check($sformatf("vec%0d_busy", v), 32'(busy), 0);
    end

    // Test 3: repeated events while another is in flight coalesce
    do_reset();
    auto_ack = 1'b0;
    f0 = flips;
    o0 = ovf1_pulses;
    exp_q.push_back(2);
    pulse_req(4'b0100);
    @(negedge clk);
    check("t3_busy", 32'(busy), 1);
    check("t3_req_id", 32'(req_id), 2);
    pulse_req(4'b0010);
    pulse_req(4'b0010);
    repeat (2) @(negedge clk);
    check("t3_overflow_count", ovf1_pulses - o0, 1);
    exp_q.push_back(1);
    auto_ack = 1'b1;
    manual_acks++;
    wait_idle("t3_stuck");
    check("t3_flips", flips - f0, 2);

    // Test 4: ack edge while idle
    do_reset();
    s0 = spur_pulses;
    d0 = done_pulses;
    f0 = flips;
    @(negedge clk);
    manual_acks++;
    repeat (8) @(negedge clk);
    check("t4_spurious", spur_pulses - s0, 1);
    check("t4_no_done", done_pulses - d0, 0);
    check("t4_no_flip", flips - f0, 0);
    check("t4_busy", 32'(busy), 0);

    // Test 5: reset in WAIT with pending events
    do_reset();
    auto_ack = 1'b0;
    exp_q.push_back(0);
    pulse_req(4'b0001);
    pulse_req(4'b1010);
    check("t5_busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_toggle", 32'(req_toggle), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_req_id", 32'(req_id), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_ovf", 32'(overflow), 0);
    check("t5_rst_spur", 32'(spurious_ack), 0);
    @(negedge clk);
    rst = 1'b0;
    f0 = flips;
    repeat (6) @(negedge clk);
    check("t5_pending_dropped", flips - f0, 0);
    exp_q.push_back(2);
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    check("t5_toggle", 32'(req_toggle), 1);
    check("t5_req_id", 32'(req_id), 2);

`ifdef CDC_ARB_TIMEOUT_EN
    // Test 6: WAIT abort without ack, then late ack is spurious
    do_reset();
    auto_ack = 1'b0;
    d0 = done_pulses;
    exp_q.push_back(3);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    check("t6_busy", 32'(busy), 1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      cnt++;
      if (timeout) break;
    end
    check("t6_timeout_cycles", cnt, TO);
    check("t6_busy_after", 32'(busy), 0);
    check("t6_no_done", done_pulses - d0, 0);
    s0 = spur_pulses;
    @(negedge clk);
    manual_acks++;
    repeat (8) @(negedge clk);
    check("t6_late_ack_spurious", spur_pulses - s0, 1);
`else
    check("timeout_tied_low", 32'(timeout), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
